// File: rtl/tl_uh_host_arbiter.sv
// Shares one TL-UH link between NumHosts hosts: round-robin A arbitration locked per burst, D routed by source prefix.
// Optional per-host outstanding limit when TL_ARB_OUTSTANDING_LIMIT_EN is defined.
module tl_uh_host_arbiter #(
   parameter int NumHosts       = 2,
   parameter int DataWidth      = 64,
   parameter int AddrWidth      = 56,
   parameter int SourceWidth    = 1,
   parameter int MaxOutstanding = 4,
   localparam int IdxW          = $clog2(NumHosts),
   localparam int MaskW         = DataWidth / 8
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NumHosts-1:0]               host_a_valid_i,
   output logic [NumHosts-1:0]               host_a_ready_o,
   input  logic [NumHosts-1:0]               host_a_first_i,
   input  logic [NumHosts-1:0]               host_a_last_i,
   input  logic [NumHosts*3-1:0]             host_a_opcode_i,
   input  logic [NumHosts*3-1:0]             host_a_size_i,
   input  logic [NumHosts*SourceWidth-1:0]   host_a_source_i,
   input  logic [NumHosts*AddrWidth-1:0]     host_a_address_i,
   input  logic [NumHosts*MaskW-1:0]         host_a_mask_i,
   input  logic [NumHosts*DataWidth-1:0]     host_a_data_i,
   output logic [NumHosts-1:0]               host_d_valid_o,
   input  logic [NumHosts-1:0]               host_d_ready_i,
   input  logic                              host_d_last_i,
   output logic                              dev_a_valid_o,
   input  logic                              dev_a_ready_i,
   output logic [2:0]                        dev_a_opcode_o,
   output logic [2:0]                        dev_a_size_o,
   output logic [AddrWidth-1:0]              dev_a_address_o,
   output logic [MaskW-1:0]                  dev_a_mask_o,
   output logic [DataWidth-1:0]              dev_a_data_o,
   output logic [SourceWidth+IdxW-1:0]       dev_a_source_o,
   input  logic                              dev_d_valid_i,
   output logic                              dev_d_ready_o,
   input  logic [SourceWidth+IdxW-1:0]       dev_d_source_i,
   output logic [SourceWidth-1:0]            host_d_source_o
);

   if (NumHosts < 2 || NumHosts > 8 || MaxOutstanding < 1) begin : g_param_check
      $error("tl_uh_host_arbiter: unsupported NumHosts/MaxOutstanding");
   end

   typedef enum logic {A_UNLOCKED, A_LOCKED} a_state_e;

   a_state_e            state_q, state_d;
   logic [IdxW-1:0]     a_sel_q, a_sel_d, rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]     rr_idx, grant_idx, d_idx;
   logic [IdxW:0]       cand_sum;
   logic [NumHosts-1:0] a_elig;
   logic                rr_found, a_granted, a_fire, a_first, a_last, d_idx_ok;

`ifdef TL_ARB_OUTSTANDING_LIMIT_EN
   localparam int CntW = $clog2(MaxOutstanding + 1);
   logic [CntW-1:0]     cnt_q [NumHosts];
   logic [NumHosts-1:0] at_limit, cnt_inc, cnt_dec;

   always_comb begin
      at_limit = '0;
      for (int h = 0; h < NumHosts; h++) at_limit[h] = (cnt_q[h] == CntW'(MaxOutstanding));
      cnt_inc = (a_fire && a_first) ? (NumHosts'(1) << grant_idx) : '0;
      cnt_dec = (dev_d_ready_o && host_d_last_i) ? host_d_valid_o : '0;
   end

   // Only fresh grants are masked; an owner mid-burst always keeps the link.
   assign a_elig = host_a_valid_i & ~at_limit;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int h = 0; h < NumHosts; h++) cnt_q[h] <= '0;
      end else begin
         for (int h = 0; h < NumHosts; h++) begin
            assert (!(cnt_dec[h] && !cnt_inc[h] && cnt_q[h] == '0))
               else $error("tl_uh_host_arbiter: outstanding counter underflow on host %0d", h);
            if (cnt_inc[h] && !cnt_dec[h])      cnt_q[h] <= cnt_q[h] + CntW'(1);
            else if (cnt_dec[h] && !cnt_inc[h]) cnt_q[h] <= cnt_q[h] - CntW'(1);
         end
      end
   end
`else
   logic unused_d_last;
   assign unused_d_last = host_d_last_i;
   assign a_elig        = host_a_valid_i;
`endif

   // First eligible host at or after rr_ptr, wrapping modulo NumHosts.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = rr_ptr_q;
      cand_sum = '0;
      for (int k = 0; k < NumHosts; k++) begin
         cand_sum = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
         if (cand_sum >= (IdxW+1)'(NumHosts)) cand_sum = cand_sum - (IdxW+1)'(NumHosts);
         if (!rr_found && a_elig[cand_sum[IdxW-1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = cand_sum[IdxW-1:0];
         end
      end
   end

   assign grant_idx      = (state_q == A_LOCKED) ? a_sel_q : rr_idx;
   assign a_granted      = !rst_i && ((state_q == A_LOCKED) || rr_found);
   assign dev_a_valid_o  = a_granted && host_a_valid_i[grant_idx];
   assign host_a_ready_o = (a_granted && dev_a_ready_i) ? (NumHosts'(1) << grant_idx) : '0;
   assign a_fire         = dev_a_valid_o && dev_a_ready_i;
   assign a_first        = host_a_first_i[grant_idx];
   assign a_last         = host_a_last_i[grant_idx];

   assign dev_a_opcode_o  = host_a_opcode_i[grant_idx*3 +: 3];
   assign dev_a_size_o    = host_a_size_i[grant_idx*3 +: 3];
   assign dev_a_address_o = host_a_address_i[grant_idx*AddrWidth +: AddrWidth];
   assign dev_a_mask_o    = host_a_mask_i[grant_idx*MaskW +: MaskW];
   assign dev_a_data_o    = host_a_data_i[grant_idx*DataWidth +: DataWidth];
   assign dev_a_source_o  = {grant_idx, host_a_source_i[grant_idx*SourceWidth +: SourceWidth]};

   always_comb begin
      state_d  = state_q;
      a_sel_d  = a_sel_q;
      rr_ptr_d = rr_ptr_q;
      if (a_fire) begin
         if (a_last) begin
            state_d  = A_UNLOCKED;
            rr_ptr_d = (grant_idx == IdxW'(NumHosts - 1)) ? '0 : grant_idx + IdxW'(1);
         end else if (a_first) begin
            state_d = A_LOCKED;
            a_sel_d = grant_idx;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= A_UNLOCKED;
         a_sel_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         a_sel_q  <= a_sel_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign d_idx           = dev_d_source_i[SourceWidth+IdxW-1 -: IdxW];
   assign d_idx_ok        = (d_idx <= IdxW'(NumHosts - 1));
   assign host_d_valid_o  = (!rst_i && dev_d_valid_i && d_idx_ok) ? (NumHosts'(1) << d_idx) : '0;
   assign dev_d_ready_o   = !rst_i && d_idx_ok && host_d_ready_i[d_idx];
   assign host_d_source_o = dev_d_source_i[SourceWidth-1:0];

   always_ff @(posedge clk_i) begin
      if (!rst_i && dev_d_valid_i)
         assert (d_idx_ok) else $error("tl_uh_host_arbiter: D source prefix %0d out of range", d_idx);
   end

endmodule

// File: doc/tl_uh_host_arbiter.md
Name: tl_uh_host_arbiter

Overview:
- Shares one TL-UH link, the upstream side of the TL-to-AXI bridge, between NumHosts TL-UH hosts.
- A channel: round-robin arbitration, locked for the length of a burst.
- Host index is prepended to the source, so the downstream source is {idx, source}.
- D channel: routed back to the owning host by the source MSBs, with the prefix stripped.
- Sits between the core-side TL hosts and the bridge, whose SourceWidth equals SourceWidth+IdxW here.

Parameters:
- NumHosts, 2, number of upstream TL-UH hosts (2..8). IdxW = $clog2(NumHosts).
- DataWidth, 64, TL data width in bits.
- AddrWidth, 56, TL address width.
- SourceWidth, 1, per-host source width. Downstream source width is SourceWidth+IdxW.
- MaxOutstanding, 4, per-host cap on outstanding transactions. Used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- host_a_valid_i  in  NumHosts  per-host A valid.
- host_a_ready_o  out  NumHosts  per-host A ready.
- host_a_first_i  in  NumHosts  beat is the first of its message (from each host's burst tracker).
- host_a_last_i  in  NumHosts  beat is the last of its message.
- host_a_opcode_i  in  NumHosts*3  A opcode.
- host_a_size_i  in  NumHosts*3  A size.
- host_a_source_i  in  NumHosts*SourceWidth  A source.
- host_a_address_i  in  NumHosts*AddrWidth  A address.
- host_a_mask_i  in  NumHosts*DataWidth/8  A mask.
- host_a_data_i  in  NumHosts*DataWidth  A data.
- host_d_valid_o  out  NumHosts  per-host D valid.
- host_d_ready_i  in  NumHosts  per-host D ready.
- host_d_last_i  in  1  downstream D beat is the last of its message.
- dev_a_valid_o  out  1  merged A valid.
- dev_a_ready_i  in  1  merged A ready.
- dev_a_{opcode,size,address,mask,data}_o  out  as above  merged A fields.
- dev_a_source_o  out  SourceWidth+IdxW  merged A source, {idx, source}.
- dev_d_valid_i  in  1  downstream D valid.
- dev_d_ready_o  out  1  downstream D ready.
- dev_d_source_i  in  SourceWidth+IdxW  downstream D source.
- host_d_source_o  out  SourceWidth  D source with the prefix stripped; broadcast to all hosts.
- D opcode/size/denied/data are broadcast to all hosts by the parent, not routed through this block.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - a_locked=0, rr_ptr=0, all outstanding counters 0.
  - Outputs: host_a_ready_o=0, dev_a_valid_o=0, host_d_valid_o=0, dev_d_ready_o=0.
  - dev_a payload outputs are don't-care.
- A arbitration:
  - Unlocked: grant is the first valid host at or after rr_ptr, wrapping modulo NumHosts.
  - Locked: grant = a_sel_q.
- A mux and handshake:
  - dev_a_valid_o = valid of the granted host; fields come from that host; source = {grant_idx, src}.
  - host_a_ready_o[g] = dev_a_ready_i for the granted host only; other bits are 0.
  - Combinational paths host valid→dev valid and dev ready→host ready are allowed. The bridge's input regslice breaks the loop.
- A lock FSM, states UNLOCKED / LOCKED:
  - UNLOCKED→LOCKED on a fire with first=1 and last=0; a_sel_q captures the grant.
  - LOCKED→UNLOCKED on a fire with last=1.
  - A single-beat message (first=last=1) stays UNLOCKED.
- Round-robin pointer:
  - rr_ptr advances to grant+1 (mod NumHosts) on every fire with last=1.
  - A host therefore cannot win twice in a row while another host is waiting.
- D routing:
  - idx = dev_d_source_i[SourceWidth+IdxW-1 -: IdxW].
  - host_d_valid_o = onehot(idx) & {NumHosts{dev_d_valid_i}}.
  - dev_d_ready_o = host_d_ready_i[idx].
  - host_d_source_o = low SourceWidth bits of dev_d_source_i.
  - An idx ≥ NumHosts is unreachable; a simulation assertion fires if it occurs.
- A and D are independent: A and D may fire in the same cycle without interaction.
- Reset mid-burst: lock and pointer clear. Upstream hosts reset together with this block.

Optional Feature:
- Macro: TL_ARB_OUTSTANDING_LIMIT_EN.
- When defined:
  - Per-host counter cnt[h], width $clog2(MaxOutstanding+1).
  - +1 on an A fire with first=1 from h; −1 on a D fire with host_d_last_i=1 to h.
  - Simultaneous +1 and −1 leave the count unchanged.
  - A host with cnt==MaxOutstanding is masked from the unlocked grant. A locked burst is never masked.
  - Assertion: no underflow.
- When undefined: no counters and no masking. Rely on the source-space limit only.

Test Plan:
- Host0 and host1 each issue a single-beat Get, valid in the same cycle, rr_ptr=0 → host0 fires first with dev source {0,s}; host1 fires the next cycle with {1,s}; rr_ptr=0 afterwards.
- Host1 issues a 4-beat PutFull (size=5, 64-bit bus) while host0 asserts valid from beat 2 → all 4 host1 beats are contiguous; host0 is granted only after host1's last beat.
- Downstream stalls with dev_a_ready_i=0 for 3 cycles mid-burst → grant and lock hold; no beats are lost or duplicated.
- D beat with source {1,0} and host1 ready=0 → host_d_valid_o=2'b10 and dev_d_ready_o=0 until host1 ready rises; host_d_source_o=0.
- With TL_ARB_OUTSTANDING_LIMIT_EN and MaxOutstanding=2, host0 issues 3 Gets and no D returns → the 3rd is not granted; it is granted the cycle after one AccessAckData last beat for host0.
- Assert rst_i mid-burst (LOCKED) → the next cycle all ready/valid outputs are 0; after release, arbitration restarts at host0.
